// File: rtl/ak5394a_pkg.sv
// Shared constants and calibration state type for the AK5394A slave-mode receiver.
package ak5394a_pkg;

  localparam int FRAME_MCLKS = 256;
  localparam int SLOTS       = 64;
  localparam int L_MSB_SLOT  = 1;
  localparam int R_MSB_SLOT  = 33;
  localparam int SAMPLE_BITS = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    RUN  = 2'd2
  } cal_state_e;

endpackage

// File: rtl/ak5394a_clkgen.sv
// Frame timebase: 256-MCLK counter, registered SCLK/LRCK and decoded capture/publish strobes.
module ak5394a_clkgen
  import ak5394a_pkg::*;
(
  input  logic ADC_MCLK,
  input  logic nReset,
  output logic ADC_SCLK,
  output logic ADC_LRCK,
  output logic capture_l,
  output logic capture_r,
  output logic frame_end
);

  localparam logic [5:0] L_FIRST  = 6'(L_MSB_SLOT);
  localparam logic [5:0] L_LAST   = 6'(L_MSB_SLOT + SAMPLE_BITS - 1);
  localparam logic [5:0] R_FIRST  = 6'(R_MSB_SLOT);
  localparam logic [5:0] R_LAST   = 6'(R_MSB_SLOT + SAMPLE_BITS - 1);
  localparam logic [7:0] LAST_CNT = 8'(FRAME_MCLKS - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic       lrck_q, lrck_d;
  logic [5:0] slot;
  logic       mid_high;

  always_comb begin
    cnt_d  = cnt_q + 8'd1;
    // Taken from the next count so the registered clocks stay aligned with cnt_q.
    sclk_d = cnt_d[1];
    lrck_d = cnt_d[7];
  end

  always_ff @(posedge ADC_MCLK) begin
    if (!nReset) begin
      cnt_q  <= 8'd0;
      sclk_q <= 1'b0;
      lrck_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
      lrck_q <= lrck_d;
    end
  end

  always_comb begin
    slot      = cnt_q[7:2];
    mid_high  = (cnt_q[1:0] == 2'b11);
    capture_l = mid_high && (slot >= L_FIRST) && (slot <= L_LAST);
    capture_r = mid_high && (slot >= R_FIRST) && (slot <= R_LAST);
    frame_end = (cnt_q == LAST_CNT);
  end

  assign ADC_SCLK = sclk_q;
  assign ADC_LRCK = lrck_q;

endmodule

// File: rtl/ak5394a_rx.sv
// AK5394A slave-mode I2S receiver: deserializer, calibration gate and sample-pair handshake.
module ak5394a_rx
  import ak5394a_pkg::*;
#(
  parameter int SAMPLE_BITS = ak5394a_pkg::SAMPLE_BITS,
  parameter int CAL_FRAMES  = 8704
) (
  input  logic                   ADC_MCLK,
  input  logic                   nReset,
  input  logic                   ADC_RSTN,
  input  logic                   ADC_SDATA,
  output logic                   ADC_SCLK,
  output logic                   ADC_LRCK,
  output logic [SAMPLE_BITS-1:0] left_sample,
  output logic [SAMPLE_BITS-1:0] right_sample,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   cal_done,
  output logic                   overrun,
  output cal_state_e             cal_state
);

  localparam int FW = $clog2(CAL_FRAMES + 1);

  logic capture_l, capture_r, frame_end;

  ak5394a_clkgen u_clkgen (
    .ADC_MCLK  (ADC_MCLK),
    .nReset    (nReset),
    .ADC_SCLK  (ADC_SCLK),
    .ADC_LRCK  (ADC_LRCK),
    .capture_l (capture_l),
    .capture_r (capture_r),
    .frame_end (frame_end)
  );

  logic                   rstn_meta_q, rstn_s_q;
  cal_state_e             state_q, state_d;
  logic [FW-1:0]          frame_cnt_q, frame_cnt_d;
  logic [SAMPLE_BITS-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic [SAMPLE_BITS-1:0] left_q, left_d, right_q, right_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   accept, publish;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;

    if (capture_l) shift_l_d = {shift_l_q[SAMPLE_BITS-2:0], ADC_SDATA};
    if (capture_r) shift_r_d = {shift_r_q[SAMPLE_BITS-2:0], ADC_SDATA};

    case (state_q)
      IDLE: begin
        frame_cnt_d = '0;
        if (rstn_s_q) state_d = CAL;
      end
      CAL: begin
        if (frame_end) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          if (frame_cnt_d == FW'(CAL_FRAMES)) state_d = RUN;
        end
      end
      RUN: ;
      default: state_d = IDLE;
    endcase

    if (!rstn_s_q) begin
      state_d     = IDLE;
      frame_cnt_d = '0;
    end

    // Handshake: a pair transfers on any cycle with sample_valid && sample_ready;
    // a publish while a pair is still pending and not transferring overwrites it and sets overrun.
    accept  = valid_q && sample_ready;
    publish = frame_end && (state_q == RUN) && rstn_s_q;
    if (accept) valid_d = 1'b0;
    if (publish) begin
      left_d  = shift_l_q;
      right_d = shift_r_q;
      valid_d = 1'b1;
      if (valid_q && !sample_ready) overrun_d = 1'b1;
    end
    if (!rstn_s_q) valid_d = 1'b0;
  end

  always_ff @(posedge ADC_MCLK) begin
    if (!nReset) begin
      rstn_meta_q <= 1'b0;
      rstn_s_q    <= 1'b0;
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      shift_l_q   <= '0;
      shift_r_q   <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rstn_meta_q <= ADC_RSTN;
      rstn_s_q    <= rstn_meta_q;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign left_sample  = left_q;
  assign right_sample = right_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign cal_done     = (state_q == RUN);
  assign cal_state    = state_q;

endmodule

// File: tb/tb_ak5394a_rx.sv
// Directed/random bench for ak5394a_rx with an I2S source model and frame-level expectations.
module tb_ak5394a_rx;

  localparam int CAL_FRAMES = 4;

  logic        ADC_MCLK = 1'b0;
  logic        nReset = 1'b0;
  logic        ADC_RSTN = 1'b0;
  logic        ADC_SDATA = 1'b0;
  logic        sample_ready = 1'b0;
  logic        ADC_SCLK, ADC_LRCK;
  logic [23:0] left_sample, right_sample;
  logic        sample_valid, cal_done, overrun;
  ak5394a_pkg::cal_state_e cal_state;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] tx_l = 24'd0;
  logic [23:0] tx_r = 24'd0;
  logic [7:0]  tb_cnt;
  logic [47:0] exp_q[$];

  always #5 ADC_MCLK = ~ADC_MCLK;

  ak5394a_rx #(.SAMPLE_BITS(24), .CAL_FRAMES(CAL_FRAMES)) dut (
    .ADC_MCLK     (ADC_MCLK),
    .nReset       (nReset),
    .ADC_RSTN     (ADC_RSTN),
    .ADC_SDATA    (ADC_SDATA),
    .ADC_SCLK     (ADC_SCLK),
    .ADC_LRCK     (ADC_LRCK),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .cal_done     (cal_done),
    .overrun      (overrun),
    .cal_state    (cal_state)
  );

  // Position within the 256-MCLK frame; zero in the first cycle after reset.
  always @(posedge ADC_MCLK) begin
    if (!nReset) tb_cnt <= 8'd0;
    else         tb_cnt <= tb_cnt + 8'd1;
  end

  // I2S source: left MSB in slot 1, right MSB in slot 33, noise elsewhere.
  always @(negedge ADC_MCLK) begin
    if (tb_cnt[7:2] >= 6'd1 && tb_cnt[7:2] <= 6'd24)
      ADC_SDATA = tx_l[24 - int'(tb_cnt[7:2])];
    else if (tb_cnt[7:2] >= 6'd33 && tb_cnt[7:2] <= 6'd56)
      ADC_SDATA = tx_r[56 - int'(tb_cnt[7:2])];
    else
      ADC_SDATA = 1'($urandom_range(0, 1));
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  task automatic goto(input logic [7:0] c);
    int n;
    n = 0;
    do begin
      @(negedge ADC_MCLK);
      n++;
    end while (tb_cnt !== c && n < 600);
    if (tb_cnt !== c) begin
      vectors++;
      miscompares++;
      $error("FAIL goto: cnt %0d wanted %0d", tb_cnt, c);
    end
  endtask

  function automatic logic [23:0] rnd24();
    return 24'($urandom_range(1, 24'hFFFFFF));
  endfunction

  task automatic check_pair(input string tag, input logic [47:0] exp);
    chk24({tag, "_left"}, left_sample, exp[47:24]);
    chk24({tag, "_right"}, right_sample, exp[23:0]);
    chk1({tag, "_valid"}, sample_valid, 1'b1);
  endtask

  // Raise ADC_RSTN at a frame start and follow the gate through to the first published pair.
  task automatic calibrate(input string tag);
    logic [23:0] l, r;
    goto(8'd0);
    ADC_RSTN = 1'b1;
    sample_ready = 1'b1;
    for (int f = 0; f < CAL_FRAMES; f++) begin
      if (f > 0) goto(8'd0);
      tx_l = rnd24();
      tx_r = rnd24();
      goto(8'd255);
      chk1({tag, "_cal_valid"}, sample_valid, 1'b0);
      chk1({tag, "_cal_done_early"}, cal_done, 1'b0);
    end
    goto(8'd0);
    l = rnd24();
    r = rnd24();
    tx_l = l;
    tx_r = r;
    goto(8'd128);
    chk1({tag, "_cal_done"}, cal_done, 1'b1);
    chk1({tag, "_cal_end_valid"}, sample_valid, 1'b0);
    goto(8'd255);
    chk1({tag, "_cal_end_valid255"}, sample_valid, 1'b0);
    goto(8'd0);
    check_pair({tag, "_first"}, {l, r});
  endtask

  initial begin
    logic [47:0] exp;
    logic [23:0] l, r;

    repeat (5) @(negedge ADC_MCLK);
    nReset = 1'b1;
    repeat (100) @(negedge ADC_MCLK);
    nReset = 1'b0;
    repeat (10) @(negedge ADC_MCLK);
    chk1("rst_sclk", ADC_SCLK, 1'b0);
    chk1("rst_lrck", ADC_LRCK, 1'b0);
    chk24("rst_left", left_sample, 24'd0);
    chk24("rst_right", right_sample, 24'd0);
    chk1("rst_valid", sample_valid, 1'b0);
    chk1("rst_cal_done", cal_done, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);

    nReset = 1'b1;
    for (int k = 0; k < 512; k++) begin
      chk1("sclk", ADC_SCLK, ((k / 2) % 2) == 1);
      chk1("lrck", ADC_LRCK, (k % 256) >= 128);
      @(negedge ADC_MCLK);
    end
    chk1("idle_cal_done", cal_done, 1'b0);

    calibrate("cal1");

    // Directed extreme pair followed by random pairs, consumer always ready.
    for (int i = 0; i < 7; i++) begin
      l = (i == 0) ? 24'h800001 : rnd24();
      r = (i == 0) ? 24'h7FFFFE : rnd24();
      tx_l = l;
      tx_r = r;
      exp_q.push_back({l, r});
      goto(8'd255);
      chk1("valid_pre_pub", sample_valid, 1'b0);
      goto(8'd0);
      exp = exp_q.pop_front();
      check_pair("data", exp);
      chk1("data_overrun", overrun, 1'b0);
      goto(8'd1);
      chk1("valid_one_cycle", sample_valid, 1'b0);
    end

    // Acceptance in the same cycle as the publish edge.
    sample_ready = 1'b0;
    tx_l = 24'h5A5A5A;
    tx_r = 24'hA5A5A5;
    goto(8'd0);
    check_pair("simul_a", {24'h5A5A5A, 24'hA5A5A5});
    l = rnd24();
    r = rnd24();
    tx_l = l;
    tx_r = r;
    goto(8'd255);
    sample_ready = 1'b1;
    goto(8'd0);
    check_pair("simul_b", {l, r});
    chk1("simul_overrun", overrun, 1'b0);
    goto(8'd1);
    chk1("simul_accept", sample_valid, 1'b0);

    // Backpressure across two frames.
    sample_ready = 1'b0;
    tx_l = 24'h111111;
    tx_r = 24'h222222;
    goto(8'd0);
    check_pair("bp_first", {24'h111111, 24'h222222});
    chk1("bp_first_overrun", overrun, 1'b0);
    tx_l = 24'h333333;
    tx_r = 24'h444444;
    goto(8'd0);
    check_pair("bp_second", {24'h333333, 24'h444444});
    chk1("bp_overrun", overrun, 1'b1);
    sample_ready = 1'b1;
    l = rnd24();
    r = rnd24();
    tx_l = l;
    tx_r = r;
    goto(8'd1);
    chk1("bp_accept", sample_valid, 1'b0);
    chk1("bp_overrun_sticky", overrun, 1'b1);
    goto(8'd0);
    check_pair("bp_after", {l, r});
    chk1("bp_overrun_held", overrun, 1'b1);

    // Recalibration with a pending pair outstanding.
    goto(8'd1);
    sample_ready = 1'b0;
    tx_l = rnd24();
    tx_r = rnd24();
    goto(8'd0);
    chk1("recal_pending", sample_valid, 1'b1);
    goto(8'd80);
    ADC_RSTN = 1'b0;
    goto(8'd82);
    chk1("recal_cal_done_2", cal_done, 1'b1);
    chk1("recal_valid_2", sample_valid, 1'b1);
    goto(8'd83);
    chk1("recal_cal_done_3", cal_done, 1'b0);
    chk1("recal_valid_3", sample_valid, 1'b0);
    goto(8'd0);
    goto(8'd128);
    chk1("recal_idle_valid", sample_valid, 1'b0);
    chk1("recal_idle_cal_done", cal_done, 1'b0);
    calibrate("cal2");

    nReset = 1'b0;
    repeat (2) @(negedge ADC_MCLK);
    chk1("final_overrun", overrun, 1'b0);
    chk1("final_valid", sample_valid, 1'b0);
    chk1("final_cal_done", cal_done, 1'b0);
    chk24("final_left", left_sample, 24'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
